// File: rtl/regfile_scoreboard_pkg.sv
// pipe_pkg: constants and types shared by the register file / scoreboard slice.
package pipe_pkg;

  // Architectural register addressing
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // Default datapath and scoreboard counter widths
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 2;

  // Write-back source select shared by the RTL
  function automatic logic [DEF_DATA_W-1:0] wb_select(
    input logic                  memtoreg,
    input logic [DEF_DATA_W-1:0] alu_result,
    input logic [DEF_DATA_W-1:0] mem_data
  );
    return memtoreg ? mem_data : alu_result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode read ports, issue reservation and write-back
// bundle. The pipeline (master) drives addresses and write-back, the register
// file (slave) returns data, busy flags, stall and the sticky error.
interface regfile_scoreboard_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  // Decode-stage reads
  reg_addr_t           rs_addr;
  reg_addr_t           rt_addr;
  logic                rs_used;
  logic                rt_used;
  logic [DATA_W-1:0]   rs_data;
  logic [DATA_W-1:0]   rt_data;
  logic                rs_busy;
  logic                rt_busy;
  logic                stall;

  // Destination reservation at issue
  logic                issue_valid;
  reg_addr_t           issue_reg;

  // Write-back from MEM/WB
  logic                wb_regwrite;
  reg_addr_t           wb_reg;
  logic                wb_memtoreg;
  logic [DATA_W-1:0]   wb_alu_result;
  logic [DATA_W-1:0]   wb_mem_data;

  // Scoreboard health
  logic                sb_error;

  modport master (
    output rs_addr, rt_addr, rs_used, rt_used,
    output issue_valid, issue_reg,
    output wb_regwrite, wb_reg, wb_memtoreg, wb_alu_result, wb_mem_data,
    input  rs_data, rt_data, rs_busy, rt_busy, stall, sb_error
  );

  modport slave (
    input  rs_addr, rt_addr, rs_used, rt_used,
    input  issue_valid, issue_reg,
    input  wb_regwrite, wb_reg, wb_memtoreg, wb_alu_result, wb_mem_data,
    output rs_data, rt_data, rs_busy, rt_busy, stall, sb_error
  );

endinterface

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: saturating up/down in-flight write counter for one register.
// An increment at the maximum or a decrement at zero is dropped and flagged
// on o_err for that cycle; simultaneous inc and dec cancel without error.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_inc_only;
  logic             w_dec_only;

  assign w_at_max   = (r_count == {CNT_W{1'b1}});
  assign w_at_zero  = (r_count == '0);
  assign w_inc_only = i_inc & ~i_dec;
  assign w_dec_only = i_dec & ~i_inc;

  // Next count: step only when the move stays inside the counter range
  always_comb begin
    // NOTE: default assigned first so every path drives it and no latch is inferred.
    w_count_nxt = r_count;
    if (w_inc_only && !w_at_max) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_dec_only && !w_at_zero) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;
  assign o_err   = (w_inc_only & w_at_max) | (w_dec_only & w_at_zero);

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x DATA_W register file with two combinational read
// ports, one write-back port and a per-register in-flight write scoreboard
// that raises stall for reads of registers with unretired writes.
// Optional feature macro: RF_BYPASS_EN -- forwards same-cycle write-back data
// to the read ports and treats the retiring write as already done for busy.
module regfile_scoreboard
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_sb_error;

  logic [CNT_W-1:0]  w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_err;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_we;

  reg_addr_t         w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_rd_busy [2];

  // ---------------------------------------------------------------------------
  // Write-back
  // ---------------------------------------------------------------------------
  assign w_wb_data = bus.wb_memtoreg ? bus.wb_mem_data : bus.wb_alu_result;
  assign w_wb_we   = bus.wb_regwrite && (bus.wb_reg != ZERO_REG);

  // Register array: cleared by reset, written on an enabled non-zero write-back
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this array is reset on purpose -- reset must leave every architectural register at 0.
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[bus.wb_reg] <= w_wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: one counter per register 1..31; register 0 is never tracked
  // ---------------------------------------------------------------------------
  assign w_count[0] = '0;
  assign w_err[0]   = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    wire w_inc = bus.issue_valid && (bus.issue_reg == REG_ADDR_W'(g));
    wire w_dec = bus.wb_regwrite && (bus.wb_reg == REG_ADDR_W'(g));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .o_count (w_count[g]),
      .o_err   (w_err[g])
    );
  end

  // Sticky error: any counter overflow/underflow latches until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_error <= 1'b0;
    end else if (|w_err) begin
      r_sb_error <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (0 = rs, 1 = rt)
  // ---------------------------------------------------------------------------
  assign w_rd_addr[0] = bus.rs_addr;
  assign w_rd_addr[1] = bus.rt_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    wire             w_nz  = (w_rd_addr[p] != ZERO_REG);
    wire [CNT_W-1:0] w_cnt = w_count[w_rd_addr[p]];
`ifdef RF_BYPASS_EN
    // Forward only outside reset so all outputs read 0 while rst is high
    wire w_hit = w_wb_we && !rst && (w_rd_addr[p] == bus.wb_reg);
    assign w_rd_data[p] = w_hit ? w_wb_data : r_regs[w_rd_addr[p]];
    assign w_rd_busy[p] = w_nz && (w_hit ? (w_cnt > CNT_W'(1)) : (w_cnt != '0));
`else
    assign w_rd_data[p] = r_regs[w_rd_addr[p]];
    assign w_rd_busy[p] = w_nz && (w_cnt != '0);
`endif
  end

  assign bus.rs_data  = w_rd_data[0];
  assign bus.rt_data  = w_rd_data[1];
  assign bus.rs_busy  = w_rd_busy[0];
  assign bus.rt_busy  = w_rd_busy[1];
  assign bus.stall    = (bus.rs_used & w_rd_busy[0]) | (bus.rt_used & w_rd_busy[1]);
  assign bus.sb_error = r_sb_error;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and write-back data width.
REQ-002 SHALL have parameter CNT_W, default 2, meaning width of the per-register in-flight write counter (maximum 2^CNT_W-1 outstanding writes).
REQ-003 SHALL have the ports clk and rst; one clock (clk, rising edge); reset rst is asynchronous and active-high.
REQ-004 SHALL have the port clk  in  1  pipeline clock.
REQ-005 SHALL have the port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have the ports rs_addr, rt_addr  in  5 each  decode-stage source register addresses.
REQ-007 SHALL have the ports rs_used, rt_used  in  1 each  decode instruction actually reads that source.
REQ-008 SHALL have the ports rs_data, rt_data  out  DATA_W each  read data, combinational.
REQ-009 SHALL have the ports rs_busy, rt_busy  out  1 each  source has an outstanding unretired write.
REQ-010 SHALL have the port stall  out  1  (rs_used & rs_busy) | (rt_used & rt_busy).
REQ-011 SHALL have the ports issue_valid (in, 1) and issue_reg (in, 5)  decode reserves a destination for an issuing register-writing instruction.
REQ-012 SHALL have the ports wb_regwrite (in, 1) and wb_reg (in, 5)  write-back enable and destination, from the MEM/WB register.
REQ-013 SHALL have the ports wb_memtoreg (in, 1), wb_alu_result (in, DATA_W) and wb_mem_data (in, DATA_W)  write-back source select and operands.
REQ-014 SHALL have the port sb_error  out  1  sticky counter overflow/underflow flag.

Function
REQ-015 SHALL hold 32 registers of DATA_W bits.
REQ-016 SHALL take write data as wb_mem_data when wb_memtoreg=1, else wb_alu_result.
REQ-017 SHALL write register wb_reg at the rising edge when wb_regwrite=1 and wb_reg!=0.
REQ-018 SHALL keep register 0 reading 0; writes to it are ignored and it is never reserved or released.
REQ-019 SHALL give read latency 0: rs_data/rt_data follow the addresses combinationally.
REQ-020 SHALL keep one counter per register 1..31; issue_valid increments count[issue_reg], and wb_regwrite decrements count[wb_reg], at the clock edge.
REQ-021 SHALL leave the count unchanged, with no error, when issue and release target the same register in the same cycle.
REQ-022 SHALL ignore an increment at maximum count, leave the count unchanged and set sb_error.
REQ-023 SHALL ignore a decrement at count 0, leave the count unchanged and set sb_error; the register write still occurs.
REQ-024 SHALL drive busy = (count[addr]!=0) for addr!=0, and busy = 0 for addr=0.
REQ-025 SHALL keep sb_error set until reset.

Reset
REQ-026 SHALL, while rst=1, force all registers to 0, all counts to 0 and sb_error to 0, immediately and independent of clk.
REQ-027 SHALL, on reset asserted mid-operation, discard outstanding reservations; no write completes on the reset edge.
REQ-028 SHALL hold rs_busy, rt_busy and stall at 0 during reset.

Configuration
REQ-029 SHALL, with RF_BYPASS_EN defined, return the current-cycle write data on a read whose address equals wb_reg while wb_regwrite=1 and the address is non-zero.
REQ-030 SHALL, with RF_BYPASS_EN defined, drive busy for that register as (count>1) in that cycle.
REQ-031 SHALL, with RF_BYPASS_EN undefined, return the stored array value on reads, with busy unaffected by the same-cycle write-back (one extra stall cycle).

Structure
REQ-032 SHALL place REG_ADDR_W=5, ZERO_REG=5'd0, default DATA_W and default CNT_W in a shared package pipe_pkg.
REQ-033 SHALL implement each counter in sub-module sb_counter (inc, dec, saturating up/down, err output), instantiated 31 times.

Verification
REQ-034 SHALL cover: reset, then read rs_addr=5 -> rs_data=0, rs_busy=0, sb_error=0.
REQ-035 SHALL cover: issue r8; next cycle rs_addr=8, rs_used=1 -> stall=1; WB r8 with alu=0x1234, memtoreg=0 -> with bypass, stall=0 and rs_data=0x1234 in the WB cycle; without bypass, stall=1 in the WB cycle and rs_data=0x1234, stall=0 in the cycle after.
REQ-036 SHALL cover: WB r0 with data 0xFFFFFFFF -> r0 still reads 0, sb_error=0.
REQ-037 SHALL cover: issue r3 in the same cycle as WB release r3 at count=1 -> count stays 1, rt_busy(r3)=1, sb_error=0.
REQ-038 SHALL cover: issue r4 four times with no release -> count=3, sb_error=1; then three WBs of r4 -> rs_busy=0 and sb_error remains 1.
REQ-039 SHALL cover: WB r9 with memtoreg=1, mem=0xA5A5A5A5 at count 0 -> r9 reads 0xA5A5A5A5 and sb_error=1; assert rst mid-stream -> all outputs 0 asynchronously.
